// File: rtl/desplazador_pkg.sv
// Shared constants for the sequential shifter: mode codes and FSM state encoding.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package desplazador_pkg;

  localparam logic [1:0] MODO_SLL = 2'b00;
  localparam logic [1:0] MODO_SRL = 2'b01;
  localparam logic [1:0] MODO_SRA = 2'b10;
  localparam logic [1:0] MODO_ROL = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/desplazamiento_unitario.sv
// One-position shift/rotate step for all four modes, plus the bit shifted out.
// Latency: combinational.
// Backpressure: none; pure function of its inputs.
module desplazamiento_unitario
  import desplazador_pkg::*;
#(
  parameter int N = 8
) (
  input  logic [N-1:0] data,
  input  logic [1:0]   modo,
  output logic [N-1:0] next,
  output logic         out
);

  // Select the single-step result and the bit that leaves the word.
  always_comb begin
    next = data;
    out  = 1'b0;
    case (modo)
      MODO_SLL: begin
        out  = data[N-1];
        next = {data[N-2:0], 1'b0};
      end
      MODO_SRL: begin
        out  = data[0];
        next = {1'b0, data[N-1:1]};
      end
      MODO_SRA: begin
        out  = data[0];
        next = {data[N-1], data[N-1:1]};
      end
      default: begin
        // ROL: the top bit wraps around into bit 0.
        out  = data[N-1];
        next = {data[N-2:0], data[N-1]};
      end
    endcase
  end

endmodule

// File: rtl/desplazador_secuencial.sv
// Iterative multi-mode shifter: one bit position per clock under start/busy/done.
// Latency: done is high shamt cycles after the accept edge (next cycle for shamt=0).
// Backpressure: start is only honoured in IDLE; requests while busy are dropped.
module desplazador_secuencial
  import desplazador_pkg::*;
#(
  parameter int N  = 8,
  parameter int SW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [N-1:0]  A,
  input  logic [SW-1:0] shamt,
  input  logic [1:0]    modo,
  output logic [N-1:0]  Y,
  output logic          carry,
  output logic          busy,
  output logic          done
);

  state_t        r_state;
  logic [N-1:0]  r_work;
  logic [SW-1:0] r_cnt;
  logic [1:0]    r_modo;
  logic          r_carry_int;
  logic [N-1:0]  r_y;
  logic          r_carry;
  logic          r_busy;
  logic          r_done;

  logic [N-1:0]  w_next;
  logic          w_out;

  desplazamiento_unitario #(.N(N)) u_paso (
    .data (r_work),
    .modo (r_modo),
    .next (w_next),
    .out  (w_out)
  );

  // Control FSM, counter, work register and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_work      <= '0;
      r_cnt       <= '0;
      r_modo      <= MODO_SLL;
      r_carry_int <= 1'b0;
      r_y         <= '0;
      r_carry     <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_work      <= A;
            r_cnt       <= shamt;
            r_modo      <= modo;
            r_carry_int <= 1'b0;
            r_busy      <= 1'b1;
            if (shamt == '0) begin
              // Zero-length shift: result is the operand, nothing left the word.
              r_state <= DONE;
              r_y     <= A;
              r_carry <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_state <= SHIFT;
            end
          end
        end
        SHIFT: begin
          r_work      <= w_next;
          r_carry_int <= w_out;
          r_cnt       <= r_cnt - 1'b1;
          if (r_cnt == SW'(1)) begin
            // Final step: publish the step result directly as it lands.
            r_state <= DONE;
            r_y     <= w_next;
            r_carry <= w_out;
            r_done  <= 1'b1;
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign Y     = r_y;
  assign carry = r_carry;
  assign busy  = r_busy;
  assign done  = r_done;

endmodule

// File: tb/tb_desplazador_secuencial.sv
// Self-checking bench for desplazador_secuencial (N=8): directed table, corner sequences, random ops.
// Latency: n/a.
// Backpressure: n/a.
module tb_desplazador_secuencial;

  localparam int N  = 8;
  localparam int SW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [N-1:0]  A;
  logic [SW-1:0] shamt;
  logic [1:0]    modo;
  logic [N-1:0]  Y;
  logic          carry;
  logic          busy;
  logic          done;

  int checks = 0;
  int errors = 0;
  logic [N-1:0] prev_y;

  desplazador_secuencial #(.N(N)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .A     (A),
    .shamt (shamt),
    .modo  (modo),
    .Y     (Y),
    .carry (carry),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]   m;
    logic [N-1:0] a;
    int           s;
    logic [N-1:0] exp_y;
    logic         exp_c;
  } vec_t;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: whole shift by s positions from plain arithmetic; returns {carry, y}.
  function automatic logic [N:0] ref_shift(input logic [1:0] m, input logic [N-1:0] a, input int s);
    logic [N-1:0]        y;
    logic signed [N-1:0] sa;
    logic                c;
    sa = a;
    c  = 1'b0;
    case (m)
      2'b00: begin y = a << s;  if (s > 0) c = a[N - s]; end
      2'b01: begin y = a >> s;  if (s > 0) c = a[s - 1]; end
      2'b10: begin y = sa >>> s; if (s > 0) c = a[s - 1]; end
      default: begin y = (a << s) | (a >> (N - s)); if (s > 0) c = y[0]; end
    endcase
    return {c, y};
  endfunction

  // Issue one op, wait for done, check latency, busy/hold during shifting, result and return to idle.
  task automatic run_op(input string tag, input logic [1:0] m, input logic [N-1:0] a, input int s,
                        input logic [N-1:0] exp_y, input logic exp_c);
    int lat;
    @(negedge clk);
    start = 1'b1; A = a; shamt = SW'(s); modo = m;
    @(posedge clk); #1;
    start = 1'b0; A = $urandom; shamt = SW'($urandom); modo = 2'($urandom);
    lat = 0;
    while (!done && lat < 40) begin
      check({tag, " busy"}, int'(busy), 1);
      check({tag, " hold"}, int'(Y), int'(prev_y));
      @(posedge clk); #1;
      lat++;
    end
    check({tag, " latency"}, lat, s);
    check({tag, " busy@done"}, int'(busy), 1);
    check({tag, " Y"}, int'(Y), int'(exp_y));
    check({tag, " carry"}, int'(carry), int'(exp_c));
    prev_y = exp_y;
    @(posedge clk); #1;
    check({tag, " done low"}, int'(done), 0);
    check({tag, " idle"}, int'(busy), 0);
  endtask

  vec_t vecs[$];
  logic [N:0] r;
  int ndone;

  initial begin
    rst = 1'b1; start = 1'b0; A = '0; shamt = '0; modo = 2'b00;
    prev_y = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset Y", int'(Y), 0);
    check("reset carry", int'(carry), 0);
    check("reset busy", int'(busy), 0);
    check("reset done", int'(done), 0);
    rst = 1'b0;

    // Directed table.
    vecs.push_back('{2'b00, 8'h81, 1, 8'h02, 1'b1});
    vecs.push_back('{2'b10, 8'h90, 3, 8'hF2, 1'b0});
    vecs.push_back('{2'b01, 8'h80, 7, 8'h01, 1'b0});
    vecs.push_back('{2'b11, 8'hA5, 4, 8'h5A, 1'b0});
    vecs.push_back('{2'b11, 8'h80, 1, 8'h01, 1'b1});
    vecs.push_back('{2'b00, 8'h3C, 0, 8'h3C, 1'b0});
    vecs.push_back('{2'b10, 8'h7F, 7, 8'h00, 1'b1});
    vecs.push_back('{2'b01, 8'h01, 1, 8'h00, 1'b1});
    vecs.push_back('{2'b00, 8'h01, 7, 8'h80, 1'b0});
    foreach (vecs[i])
      run_op($sformatf("vec%0d", i), vecs[i].m, vecs[i].a, vecs[i].s, vecs[i].exp_y, vecs[i].exp_c);

    // start pulses in SHIFT and in DONE must be dropped.
    @(negedge clk);
    start = 1'b1; A = 8'hF0; shamt = 3'd4; modo = 2'b01;
    @(posedge clk); #1;
    start = 1'b0;
    ndone = 0;
    for (int k = 0; k < 12; k++) begin
      if (k == 1) begin start = 1'b1; A = 8'h11; shamt = 3'd1; modo = 2'b00; end
      if (k == 2) start = 1'b0;
      if (done) begin
        ndone++;
        start = 1'b1; A = 8'h11; shamt = 3'd1; modo = 2'b00;
      end else if (k != 1) begin
        start = 1'b0;
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    check("ignore done count", ndone, 1);
    check("ignore Y", int'(Y), 8'h0F);
    check("ignore idle", int'(busy), 0);
    prev_y = 8'h0F;

    // Reset aborts a running shift.
    @(negedge clk);
    start = 1'b1; A = 8'hFF; shamt = 3'd5; modo = 2'b00;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort Y", int'(Y), 0);
    check("abort carry", int'(carry), 0);
    check("abort busy", int'(busy), 0);
    ndone = 0;
    for (int k = 0; k < 8; k++) begin
      if (done) ndone++;
      @(posedge clk); #1;
    end
    check("abort no done", ndone, 0);
    prev_y = '0;
    run_op("after abort", 2'b00, 8'h01, 2, 8'h04, 1'b0);

    // rst and start on the same edge: reset wins.
    @(negedge clk);
    rst = 1'b1; start = 1'b1; A = 8'h55; shamt = 3'd2;
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0;
    check("rst beats start busy", int'(busy), 0);
    check("rst beats start Y", int'(Y), 0);
    prev_y = '0;

    // Random ops against the reference model.
    for (int i = 0; i < 40; i++) begin
      logic [1:0]   m;
      logic [N-1:0] a;
      int           s;
      m = 2'($urandom);
      a = N'($urandom);
      s = $urandom_range(0, N - 1);
      r = ref_shift(m, a, s);
      run_op($sformatf("rnd%0d", i), m, a, s, r[N-1:0], r[N]);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
